// File: rtl/apb_fll_if.sv
// APB3 slave bridging register accesses onto the FLL req/ack configuration
// handshake, with a synchronised lock status register and ack timeout.
module apb_fll_if #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      fll_req_o,
  output logic                      fll_wrn_o,
  output logic [1:0]                fll_add_o,
  output logic [31:0]               fll_data_o,
  input  logic                      fll_ack_i,
  input  logic [31:0]               fll_r_data_i,
  input  logic                      fll_lock_i
);

  typedef enum logic [1:0] {IDLE, REQ, LOCAL, DONE} state_e;

  // Last REQ cycle index that may still wait for an ack.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  STATUS_IDX = 3'd4;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [2:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        sticky_q, sticky_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  lock_q;

  // Only PADDR[4:2] is decoded; the rest is deliberately ignored.
  logic unused_paddr;
  assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) lock_q <= 2'b00;
    else         lock_q <= {lock_q[0], fll_lock_i};
  end

  // State and transfer registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: PSEL is only looked at in IDLE, so a master that drops
  // it mid-transfer cannot strand the FLL handshake.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          wr_d    = PWRITE;
          addr_d  = PADDR[4:2];
          wdata_d = PWDATA;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = PADDR[4] ? LOCAL : REQ;
        end
      end
      REQ: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (fll_ack_i) begin
          if (!wr_q) rdata_d = fll_r_data_i;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d    = 1'b1;
          rdata_d  = '0;
          sticky_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LOCAL: begin
        if (addr_q == STATUS_IDX) begin
          if (wr_q) begin
            if (wdata_q[1]) sticky_d = 1'b0;
          end else begin
            rdata_d = {30'd0, sticky_q, lock_q[1]};
          end
        end else begin
          err_d = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fll_req_o  = (state_q == REQ);
  assign fll_wrn_o  = wr_q;
  assign fll_add_o  = addr_q[1:0];
  assign fll_data_o = wdata_q;
  assign PREADY     = (state_q == DONE);
  assign PRDATA     = PREADY ? rdata_q : 32'd0;
  assign PSLVERR    = PREADY & err_q;

endmodule

// File: tb/tb_apb_fll_if.sv
// Directed bench for apb_fll_if: a transaction-level model predicts per-cycle
// outputs, a negedge compare process checks them, literals pin key results.
`timescale 1ns/1ps
module tb_apb_fll_if;
  localparam int T = 8;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        fll_req_o, fll_wrn_o;
  logic [1:0]  fll_add_o;
  logic [31:0] fll_data_o;
  logic        fll_ack_i;
  logic [31:0] fll_r_data_i;
  logic        fll_lock_i;
  logic        ack_tie, ack_r;

  assign fll_ack_i = ack_tie ? fll_req_o : ack_r;

  apb_fll_if #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .fll_req_o(fll_req_o),
    .fll_wrn_o(fll_wrn_o), .fll_add_o(fll_add_o), .fll_data_o(fll_data_o),
    .fll_ack_i(fll_ack_i), .fll_r_data_i(fll_r_data_i), .fll_lock_i(fll_lock_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;
  int cyc = 0, rise_cyc = 0;
  int cur_k = 0, last_lat = -1;
  bit chk_en = 0;
  bit sticky_m = 0, lock_m = 0;
  logic        exp_req = 0, exp_rdy = 0, exp_err = 0, exp_wr = 0;
  logic [1:0]  exp_add = 0;
  logic [31:0] exp_rdata = 0, exp_wd = 0, last_prdata = 0;
  logic        last_err = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectations.
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("pready",  {31'd0, PREADY},    {31'd0, exp_rdy});
      chk("pslverr", {31'd0, PSLVERR},   {31'd0, exp_err});
      chk("prdata",  PRDATA,             exp_rdata);
      chk("fll_req", {31'd0, fll_req_o}, {31'd0, exp_req});
      if (exp_req) begin
        chk("fll_wrn",  {31'd0, fll_wrn_o}, {31'd0, exp_wr});
        chk("fll_add",  {30'd0, fll_add_o}, {30'd0, exp_add});
        chk("fll_data", fll_data_o, exp_wd);
      end
      if (PREADY) begin
        last_prdata = PRDATA;
        last_err    = PSLVERR;
        last_lat    = cur_k;
      end
    end
  end

  task automatic clr_exp();
    exp_req = 0; exp_rdy = 0; exp_err = 0; exp_rdata = 0;
  endtask

  task automatic idle(input int n);
    PSEL = 0; PENABLE = 0; ack_r = 0; clr_exp(); cur_k = 0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // One APB transfer. ackd: -2 = ack tied to req, -1 = never ack,
  // d >= 0 = ack after d extra REQ cycles. drop: release PSEL in access phase.
  task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] wd,
                     input int ackd, input logic [31:0] rd, input logic drop);
    int nreq, p, idx, setup_c;
    logic [31:0] erd;
    logic eerr;
    idx = int'(a[4:2]); nreq = 0; erd = 0; eerr = 0; setup_c = cyc;
    last_lat = -1;
    if (idx < 4) begin
      if (ackd == -1) begin
        nreq = T; eerr = 1; sticky_m = 1;
      end else begin
        nreq = (ackd == -2) ? 1 : ackd + 1;
        if (!w) erd = rd;
      end
      p = nreq + 1;
    end else begin
      p = 2;
      if (idx == 4) begin
        if (w) begin
          if (wd[1]) sticky_m = 0;
        end else begin
          erd = {30'd0, sticky_m, (lock_m && (setup_c - 1 >= rise_cyc))};
        end
      end else begin
        eerr = 1;
      end
    end
    exp_wr = w; exp_add = a[3:2]; exp_wd = wd;
    PADDR = a; PWRITE = w; PWDATA = wd; PSEL = 1; PENABLE = 0;
    ack_r = 0; fll_r_data_i = 32'hBAD0_0BAD; clr_exp(); cur_k = 0;
    @(posedge clk_i); #1;
    for (int k = 1; k <= p; k++) begin
      cur_k = k;
      PENABLE = 1;
      if (drop) PSEL = 0;
      exp_req   = (k <= nreq);
      exp_rdy   = (k == p);
      exp_err   = (k == p) ? eerr : 1'b0;
      exp_rdata = (k == p) ? erd : 32'd0;
      ack_r = (idx < 4 && ackd >= 0 && k == ackd + 1);
      fll_r_data_i = (ack_tie || ack_r) ? rd : 32'hBAD0_0BAD;
      @(posedge clk_i); #1;
    end
    PSEL = 0; PENABLE = 0; ack_r = 0; clr_exp(); cur_k = 0;
  endtask

  initial begin
    rstn_i = 0; PADDR = 0; PWDATA = 0; PWRITE = 0; PSEL = 0; PENABLE = 0;
    fll_r_data_i = 0; fll_lock_i = 0; ack_tie = 0; ack_r = 0;
    #12;
    chk("rst_pready",  {31'd0, PREADY},    32'd0);
    chk("rst_pslverr", {31'd0, PSLVERR},   32'd0);
    chk("rst_prdata",  PRDATA,             32'd0);
    chk("rst_req",     {31'd0, fll_req_o}, 32'd0);
    chk("rst_wrn",     {31'd0, fll_wrn_o}, 32'd0);
    chk("rst_add",     {30'd0, fll_add_o}, 32'd0);
    chk("rst_data",    fll_data_o,         32'd0);
    @(posedge clk_i); #1 rstn_i = 1;
    chk_en = 1;
    idle(2);

    // Write FLL reg 2, ack tied to req: 3-cycle transfer.
    ack_tie = 1;
    apb(12'h008, 1, 32'hDEADBEEF, -2, 0, 0);
    chk("wr2_lat", 32'(last_lat), 32'd2);
    chk("wr2_err", {31'd0, last_err}, 32'd0);
    ack_tie = 0;
    idle(1);

    // Read FLL reg 1, ack 4 cycles late.
    apb(12'h004, 0, 0, 4, 32'h12345678, 0);
    chk("rd1_lat",  32'(last_lat), 32'd6);
    chk("rd1_data", last_prdata, 32'h12345678);
    idle(1);

    // Timeout on reg 0, then sticky flag handling.
    apb(12'h000, 0, 0, -1, 32'h55555555, 0);
    chk("to_lat",  32'(last_lat), 32'd9);
    chk("to_err",  {31'd0, last_err}, 32'd1);
    chk("to_data", last_prdata, 32'd0);
    apb(12'h010, 0, 0, -1, 0, 0);
    chk("st_sticky", last_prdata, 32'd2);
    apb(12'h010, 1, 32'h1, -1, 0, 0);
    apb(12'h010, 0, 0, -1, 0, 0);
    chk("st_keep", last_prdata, 32'd2);
    apb(12'h010, 1, 32'h2, -1, 0, 0);
    apb(12'h010, 0, 0, -1, 0, 0);
    chk("st_clr", last_prdata, 32'd0);
    idle(1);

    // Ack in the very cycle the timeout would fire: ack wins.
    apb(12'h00C, 0, 0, T - 1, 32'hA5A50F0F, 0);
    chk("edge_lat",  32'(last_lat), 32'd9);
    chk("edge_err",  {31'd0, last_err}, 32'd0);
    chk("edge_data", last_prdata, 32'hA5A50F0F);
    apb(12'h010, 0, 0, -1, 0, 0);
    chk("edge_st", last_prdata, 32'd0);
    idle(1);

    // Lock: too fresh for the first read, visible on the next one.
    fll_lock_i = 1; lock_m = 1; rise_cyc = cyc;
    apb(12'h010, 0, 0, -1, 0, 0);
    chk("lock_early", last_prdata, 32'd0);
    apb(12'h010, 0, 0, -1, 0, 0);
    chk("lock_seen", last_prdata, 32'd1);
    idle(1);

    // Unmapped addresses, including one with PSEL dropped mid-transfer.
    apb(12'h018, 0, 0, -1, 0, 0);
    chk("unm_err",  {31'd0, last_err}, 32'd1);
    chk("unm_data", last_prdata, 32'd0);
    chk("unm_lat",  32'(last_lat), 32'd2);
    apb(12'h01C, 1, 32'hFFFFFFFF, -1, 0, 1);
    // FLL write with PSEL dropped still completes the handshake.
    apb(12'h008, 1, 32'h11112222, 0, 0, 1);
    chk("drop_lat", 32'(last_lat), 32'd2);
    idle(1);

    // Timeout to set sticky, then reset in the middle of REQ.
    apb(12'h000, 0, 0, -1, 0, 0);
    chk_en = 0;
    PADDR = 12'h004; PWRITE = 1; PWDATA = 32'h0F0F0F0F; PSEL = 1; PENABLE = 0;
    @(posedge clk_i); #1 PENABLE = 1;
    @(posedge clk_i); #1;
    chk("req_before_rst", {31'd0, fll_req_o}, 32'd1);
    #2 rstn_i = 0;
    #1;
    chk("req_in_rst",    {31'd0, fll_req_o}, 32'd0);
    chk("pready_in_rst", {31'd0, PREADY},    32'd0);
    sticky_m = 0; PSEL = 0; PENABLE = 0;
    @(posedge clk_i); #1 rstn_i = 1; rise_cyc = cyc;
    chk_en = 1;
    idle(2);
    ack_tie = 1;
    apb(12'h00C, 1, 32'hCAFEF00D, -2, 0, 0);
    chk("post_rst_lat", 32'(last_lat), 32'd2);
    ack_tie = 0;
    apb(12'h010, 0, 0, -1, 0, 0);
    chk("post_rst_st", last_prdata, 32'd1);
    idle(2);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
